cl_status_led_ctrl: RTL

Parametrised status/housekeeping block for the custom-logic top. It produces the synchronised main reset, synchronises and debounces the shell's virtual DIP switches, and drives the virtual LED register from one of four runtime-selectable sources: static pattern, DIP mirror, heartbeat, or per-channel activity stretchers. It replaces the fixed two-flop reset, two-flop DIP and constant-LED logic in the CL top, and sits beside the manycore wrapper on `clk_main_a0`.

---
 rtl/cl_status_led_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cl_status_led_ctrl.sv
// cl_status_led_ctrl: reset synchroniser, virtual DIP synchroniser/debouncer
// and selectable LED driver (static, DIP mirror, heartbeat, activity).
module cl_status_led_ctrl #(
    parameter int                 width_p           = 16,
    parameter int                 rst_sync_stages_p = 2,
    parameter int                 sync_stages_p     = 2,
    parameter int                 debounce_cycles_p = 4,
    parameter int                 heartbeat_log2_p  = 24,
    parameter logic [width_p-1:0] pattern_p         = width_p'(16'hbeef),
    parameter int                 channels_p        = 4,
    parameter int                 stretch_cycles_p  = 1024
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    output logic                  rst_main_n_sync_o,
    input  logic [1:0]            mode_i,
    input  logic [channels_p-1:0] act_i,
    input  logic [width_p-1:0]    sh_cl_status_vdip,
    output logic [width_p-1:0]    vdip_o,
    output logic [width_p-1:0]    cl_sh_status_vled
);

    localparam int db_w  = $clog2(debounce_cycles_p + 1);
    localparam int act_w = $clog2(stretch_cycles_p + 1);

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'd0,
        MODE_MIRROR    = 2'd1,
        MODE_HEARTBEAT = 2'd2,
        MODE_ACTIVITY  = 2'd3
    } led_mode_e;

    logic [rst_sync_stages_p-1:0] rst_chain;
    logic                         run;
    logic [width_p-1:0]           dip_sync [sync_stages_p];
    logic [width_p-1:0]           dip_stable;
    logic [db_w-1:0]              db_cnt [width_p];
    logic [heartbeat_log2_p-1:0]  hb_cnt;
    logic                         hb;
    logic [act_w-1:0]             act_cnt [channels_p];
    logic [channels_p-1:0]        act_on;
    logic [width_p-1:0]           led_next;

    // Reset synchroniser: clears asynchronously, shifts ones in after release.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rst_chain <= '0;
        end else begin
            rst_chain <= {rst_chain[rst_sync_stages_p-2:0], 1'b1};
        end
    end

    assign rst_main_n_sync_o = rst_chain[rst_sync_stages_p-1];
    assign run               = rst_main_n_sync_o;

    // DIP synchroniser chain, held clear until the synchronised reset releases.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int i = 0; i < sync_stages_p; i++) dip_sync[i] <= '0;
        end else if (!run) begin
            for (int i = 0; i < sync_stages_p; i++) dip_sync[i] <= '0;
        end else begin
            dip_sync[0] <= sh_cl_status_vdip;
            for (int i = 1; i < sync_stages_p; i++) dip_sync[i] <= dip_sync[i-1];
        end
    end

    // Per-bit debouncer: adopt a new value only after it persists for the full count.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            dip_stable <= '0;
            for (int b = 0; b < width_p; b++) db_cnt[b] <= '0;
        end else if (!run) begin
            dip_stable <= '0;
            for (int b = 0; b < width_p; b++) db_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < width_p; b++) begin
                if (dip_sync[sync_stages_p-1][b] != dip_stable[b]) begin
                    if (db_cnt[b] == db_w'(debounce_cycles_p - 1)) begin
                        dip_stable[b] <= dip_sync[sync_stages_p-1][b];
                        db_cnt[b]     <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    assign vdip_o = dip_stable;

    // Free-running heartbeat counter; its MSB is the blink bit.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            hb_cnt <= '0;
        end else if (!run) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    assign hb = hb_cnt[heartbeat_log2_p-1];

    // Activity stretchers: a pulse (re)loads the hold time, otherwise count down to 0.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int c = 0; c < channels_p; c++) act_cnt[c] <= '0;
        end else if (!run) begin
            for (int c = 0; c < channels_p; c++) act_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < channels_p; c++) begin
                if (act_i[c]) begin
                    act_cnt[c] <= act_w'(stretch_cycles_p);
                end else if (act_cnt[c] != '0) begin
                    act_cnt[c] <= act_cnt[c] - 1'b1;
                end
            end
        end
    end

    // A channel is lit while its stretch counter is nonzero.
    always_comb begin
        act_on = '0;
        for (int c = 0; c < channels_p; c++) act_on[c] = (act_cnt[c] != '0);
    end

    // LED source mux, evaluated with the mode currently presented on mode_i.
    always_comb begin
        led_next = '0;
        case (led_mode_e'(mode_i))
            MODE_STATIC:    led_next = pattern_p;
            MODE_MIRROR:    led_next = dip_stable;
            MODE_HEARTBEAT: begin
                led_next    = pattern_p;
                led_next[0] = hb;
            end
            MODE_ACTIVITY:  led_next[channels_p-1:0] = act_on;
            default:        led_next = '0;
        endcase
    end

    // Registered LED output.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            cl_sh_status_vled <= '0;
        end else if (!run) begin
            cl_sh_status_vled <= '0;
        end else begin
            cl_sh_status_vled <= led_next;
        end
    end

endmodule
